// File: rtl/avgpool_pkg.sv
// Shared types and indexing helpers for the average-pool channel sequencer.
// Channel 0 occupies the most-significant slice of every packed multi-channel map.
package avgpool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter/selector able to hold 0..n-1, never narrower than one bit.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of channel ch inside a packed map of d slices, channel 0 at the top.
  function automatic int sliceOffset(input int ch, input int d, input int sliceBits);
    return (d - 1 - ch) * sliceBits;
  endfunction

  // Bit offset of a full HxW input slice.
  function automatic int inOffset(input int ch, input int d, input int h, input int w, input int dw);
    return sliceOffset(ch, d, h * w * dw);
  endfunction

  // Bit offset of a pooled (H/2)x(W/2) output slice.
  function automatic int outOffset(input int ch, input int d, input int h, input int w, input int dw);
    return sliceOffset(ch, d, (h / 2) * (w / 2) * dw);
  endfunction

endpackage

// File: rtl/avgpool_slice_mux.sv
// Wide selector that hands one HxW channel slice of the input map to the shared pool unit.
// Kept as its own module so the large mux can be isolated during synthesis.
module avgpool_slice_mux
  import avgpool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 6,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input  logic [H*W*D*DATA_WIDTH-1:0] i_bus,
  input  logic [chWidth(D)-1:0]       i_sel,
  output logic [H*W*DATA_WIDTH-1:0]   o_slice
);

  localparam int CW      = chWidth(D);
  localparam int SLICE_W = H * W * DATA_WIDTH;

  // Pick the slice whose channel index matches the selector; unused codes give zero.
  always_comb begin
    o_slice = '0;
    for (int c = 0; c < D; c++) begin
      if (i_sel == CW'(c)) begin
        o_slice = i_bus[inOffset(c, D, H, W, DATA_WIDTH) +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/avgpool_seq_ctrl.sv
// Time-multiplexes one external single-channel average-pool unit across all D channels.
// Each channel is held on the unit for SETTLE cycles, then its result is captured into apOutput.
module avgpool_seq_ctrl
  import avgpool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 6,
  parameter int H          = 28,
  parameter int W          = 28,
  parameter int SETTLE     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [H*W*D*DATA_WIDTH-1:0]          apInput,
  output logic [H*W*DATA_WIDTH-1:0]            pool_in,
  input  logic [(H/2)*(W/2)*DATA_WIDTH-1:0]    pool_out,
  output logic [chWidth(D)-1:0]                ch_sel,
  output logic                                 busy,
  output logic                                 done,
  output logic [(H/2)*(W/2)*D*DATA_WIDTH-1:0]  apOutput
);

  localparam int CW        = chWidth(D);
  localparam int CNTW      = chWidth(SETTLE);
  localparam int OUT_SLICE = (H / 2) * (W / 2) * DATA_WIDTH;
  localparam logic [CW-1:0]   LAST_CH  = CW'(D - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(SETTLE - 1);

  state_t                      r_state;
  state_t                      w_nextState;
  logic [CW-1:0]               r_chSel;
  logic [CW-1:0]               w_nextChSel;
  logic [CNTW-1:0]             r_cnt;
  logic [CNTW-1:0]             w_nextCnt;
  logic                        w_capture;
  logic                        r_busy;
  logic                        r_done;
  logic [OUT_SLICE*D-1:0]      r_apOutput;

  // State register; reset drops any pass in progress back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state, channel/settle-counter stepping and capture strobe.
  always_comb begin
    w_nextState = r_state;
    w_nextChSel = r_chSel;
    w_nextCnt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RUN;
          w_nextChSel = '0;
          w_nextCnt   = '0;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_capture = 1'b1;
          w_nextCnt = '0;
          if (r_chSel == LAST_CH) begin
            w_nextState = DONE;
            w_nextChSel = '0;
          end else begin
            w_nextChSel = r_chSel + 1'b1;
          end
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Channel/counter registers, registered status flags and per-channel result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chSel    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_apOutput <= '0;
    end else begin
      r_chSel <= w_nextChSel;
      r_cnt   <= w_nextCnt;
      r_busy  <= (w_nextState == RUN);
      r_done  <= (w_nextState == DONE);
      if (w_capture) begin
        for (int c = 0; c < D; c++) begin
          if (r_chSel == CW'(c)) begin
            r_apOutput[outOffset(c, D, H, W, DATA_WIDTH) +: OUT_SLICE] <= pool_out;
          end
        end
      end
    end
  end

  avgpool_slice_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .D          (D),
    .H          (H),
    .W          (W)
  ) u_sliceMux (
    .i_bus   (apInput),
    .i_sel   (r_chSel),
    .o_slice (pool_in)
  );

  assign ch_sel   = r_chSel;
  assign busy     = r_busy;
  assign done     = r_done;
  assign apOutput = r_apOutput;

endmodule

// File: tb/tb_avgpool_seq_ctrl.sv
// Bench for avgpool_seq_ctrl: three instances (D=6/SETTLE=1, D=2/SETTLE=3, D=1/SETTLE=2),
// each fed by a behavioural 2x2 average unit. Final maps and done timing go through a scoreboard.
module tb_avgpool_seq_ctrl;

  localparam int DW = 16;

  typedef struct {
    logic [383:0] data;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];

  logic          startA, startB, startC;
  logic [1535:0] apInputA;
  logic [511:0]  apInputB;
  logic [255:0]  apInputC;
  logic [255:0]  poolInA, poolInB, poolInC;
  logic [63:0]   poolOutA, poolOutB, poolOutC;
  logic [2:0]    chSelA;
  logic [0:0]    chSelB, chSelC;
  logic          busyA, busyB, busyC;
  logic          doneA, doneB, doneC;
  logic [383:0]  apOutputA;
  logic [127:0]  apOutputB;
  logic [63:0]   apOutputC;
  logic [15:0]   offB;

  // 2x2 average of a 4x4 slice, element (r,c) at element index r*4+c from the top, plus an offset.
  function automatic logic [63:0] poolModel(input logic [255:0] s, input logic [15:0] off);
    logic [63:0] r;
    logic [17:0] sum;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        sum = '0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            sum = sum + 18'(s[(15 - ((2*i+dr)*4 + 2*j+dc))*16 +: 16]);
        r[(3 - (i*2+j))*16 +: 16] = sum[17:2] + off;
      end
    end
    return r;
  endfunction

  // Packed map of d channels, each of 'elems' elements all equal to vals[c]; channel 0 at the top.
  function automatic logic [1535:0] buildMap(input int d, input int elems, input int vals[6]);
    logic [1535:0] m;
    m = '0;
    for (int c = 0; c < d; c++)
      for (int e = 0; e < elems; e++)
        m[((d - 1 - c) * elems + e) * 16 +: 16] = vals[c][15:0];
    return m;
  endfunction

  assign poolOutA = poolModel(poolInA, 16'd0);
  assign poolOutB = poolModel(poolInB, offB);
  assign poolOutC = poolModel(poolInC, 16'd0);

  avgpool_seq_ctrl #(.DATA_WIDTH(DW), .D(6), .H(4), .W(4), .SETTLE(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .apInput(apInputA), .pool_in(poolInA),
    .pool_out(poolOutA), .ch_sel(chSelA), .busy(busyA), .done(doneA), .apOutput(apOutputA));

  avgpool_seq_ctrl #(.DATA_WIDTH(DW), .D(2), .H(4), .W(4), .SETTLE(3)) dutB (
    .clk(clk), .reset(reset), .start(startB), .apInput(apInputB), .pool_in(poolInB),
    .pool_out(poolOutB), .ch_sel(chSelB), .busy(busyB), .done(doneB), .apOutput(apOutputB));

  avgpool_seq_ctrl #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4), .SETTLE(2)) dutC (
    .clk(clk), .reset(reset), .start(startC), .apInput(apInputC), .pool_in(poolInC),
    .pool_out(poolOutC), .ch_sel(chSelC), .busy(busyC), .done(doneC), .apOutput(apOutputC));

  // Free-running clock and edge counter used for done-latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected final map and done cycle, then pulse start so the next edge is E0.
  task automatic applyStimulus(input int unitSel, input logic [383:0] expData, input int lat);
    exp_t e;
    e.data = expData;
    e.cyc  = cyc + 1 + lat;
    case (unitSel)
      0: begin qA.push_back(e); startA = 1'b1; end
      1: begin qB.push_back(e); startB = 1'b1; end
      default: begin qC.push_back(e); startC = 1'b1; end
    endcase
    tick();
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  // Scoreboard monitors: every done pulse pops one expectation and checks map and timing.
  always @(negedge clk) begin
    if (doneA) begin
      if (qA.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL A unexpected done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        exp_t e;
        e = qA.pop_front();
        checkOutput("A apOutput", apOutputA, e.data);
        checkOutput("A done cycle", 384'(cyc), 384'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (doneB) begin
      if (qB.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL B unexpected done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        exp_t e;
        e = qB.pop_front();
        checkOutput("B apOutput", 384'(apOutputB), e.data);
        checkOutput("B done cycle", 384'(cyc), 384'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (doneC) begin
      if (qC.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL C unexpected done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        exp_t e;
        e = qC.pop_front();
        checkOutput("C apOutput", 384'(apOutputC), e.data);
        checkOutput("C done cycle", 384'(cyc), 384'(e.cyc));
      end
    end
  end

  // Directed sequence: reset, abort mid-run, basic pass with ignored starts, overwrite, settle, D=1.
  initial begin
    int vals[6];
    logic [1535:0] m;
    logic [63:0] expSlice;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    offB = 16'd0;
    apInputA = '0; apInputB = '0; apInputC = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    checkOutput("reset busy", 384'(busyA), 384'(0));
    checkOutput("reset done", 384'(doneA), 384'(0));
    checkOutput("reset ch_sel", 384'(chSelA), 384'(0));
    checkOutput("reset apOutput", apOutputA, 384'(0));

    vals = '{4, 8, 12, 16, 20, 24};
    m = buildMap(6, 16, vals);
    apInputA = m[1535:0];
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (2) tick();
    checkOutput("midrun busy", 384'(busyA), 384'(1));
    reset = 1'b0;
    #1;
    checkOutput("abort busy", 384'(busyA), 384'(0));
    checkOutput("abort done", 384'(doneA), 384'(0));
    checkOutput("abort ch_sel", 384'(chSelA), 384'(0));
    checkOutput("abort apOutput", apOutputA, 384'(0));
    tick();
    reset = 1'b1;
    repeat (10) tick();
    checkOutput("post-abort busy", 384'(busyA), 384'(0));

    m = buildMap(6, 4, vals);
    applyStimulus(0, m[383:0], 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("A pass1 ch_sel", 384'(chSelA), 384'(k));
      checkOutput("A pass1 busy", 384'(busyA), 384'(1));
      if (k == 2) startA = 1'b1;
      tick();
      startA = 1'b0;
    end
    checkOutput("A done busy low", 384'(busyA), 384'(0));
    startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("A after-done busy", 384'(busyA), 384'(0));
    checkOutput("A after-done done", 384'(doneA), 384'(0));

    vals = '{100, 101, 102, 103, 104, 105};
    m = buildMap(6, 16, vals);
    apInputA = m[1535:0];
    m = buildMap(6, 4, vals);
    applyStimulus(0, m[383:0], 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("A pass2 ch_sel", 384'(chSelA), 384'(k));
      expSlice = {4{16'(4 * (k + 1))}};
      checkOutput("A pass2 old slice", 384'(apOutputA[(5 - k) * 64 +: 64]), 384'(expSlice));
      tick();
    end
    repeat (2) tick();

    vals = '{10, 20, 0, 0, 0, 0};
    m = buildMap(2, 16, vals);
    apInputB = m[511:0];
    vals = '{15, 20, 0, 0, 0, 0};
    m = buildMap(2, 4, vals);
    applyStimulus(1, m[383:0], 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("B ch_sel", 384'(chSelB), 384'((k < 3) ? 0 : 1));
      if (k == 1) offB = 16'd5;
      if (k == 2) checkOutput("B slice0 before capture", 384'(apOutputB[127:64]), 384'(0));
      if (k == 3) begin
        checkOutput("B slice0 captured", 384'(apOutputB[127:64]), 384'({4{16'd15}}));
        offB = 16'd0;
      end
      tick();
    end
    repeat (2) tick();

    vals = '{7, 0, 0, 0, 0, 0};
    m = buildMap(1, 16, vals);
    apInputC = m[255:0];
    m = buildMap(1, 4, vals);
    applyStimulus(2, m[383:0], 2);
    for (int k = 0; k < 2; k++) begin
      checkOutput("C ch_sel", 384'(chSelC), 384'(0));
      checkOutput("C busy", 384'(busyC), 384'(1));
      tick();
    end
    checkOutput("C done ch_sel", 384'(chSelC), 384'(0));
    checkOutput("C done busy", 384'(busyC), 384'(0));
    repeat (3) tick();

    checkOutput("A pending", 384'(qA.size()), 384'(0));
    checkOutput("B pending", 384'(qB.size()), 384'(0));
    checkOutput("C pending", 384'(qC.size()), 384'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
